// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - select-to-one-hot decoder with a two-entry skid-buffered valid/ready pipe.
// Optional saturating error counter enabled by macro DECODER_PIPE_ERRCNT_EN.
module decoder_pipe #(
    parameter int SEL_W   = 4,
    parameter int OUTPUTS = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUTPUTS-1:0] out_onehot,
    output logic               out_err,
    output logic [7:0]         err_count
);

    logic [OUTPUTS-1:0] dec_onehot;
    logic               dec_err;

    logic               out_valid_q, out_valid_d;
    logic [OUTPUTS-1:0] out_onehot_q, out_onehot_d;
    logic               out_err_q, out_err_d;
    logic               skid_valid_q, skid_valid_d;
    logic [OUTPUTS-1:0] skid_onehot_q, skid_onehot_d;
    logic               skid_err_q, skid_err_d;
    logic               in_ready_q, in_ready_d;

    logic accept;
    logic consume;

    // Decode happens before storage so both buffer entries hold finished words.
    always_comb begin
        dec_onehot = '0;
        dec_err    = 1'b1;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (in_sel == SEL_W'(i)) begin
                dec_onehot[i] = 1'b1;
                dec_err       = 1'b0;
            end
        end
    end

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_onehot_d  = out_onehot_q;
        out_err_d     = out_err_q;
        skid_valid_d  = skid_valid_q;
        skid_onehot_d = skid_onehot_q;
        skid_err_d    = skid_err_q;

        if (!out_valid_q || consume) begin
            // in_ready is low whenever the skid is full, so accept and skid refill never collide.
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_onehot_d  = skid_onehot_q;
                out_err_d     = skid_err_q;
                skid_valid_d  = 1'b0;
                skid_onehot_d = '0;
                skid_err_d    = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_onehot_d = dec_onehot;
                out_err_d    = dec_err;
            end else begin
                out_valid_d  = 1'b0;
                out_onehot_d = '0;
                out_err_d    = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d  = 1'b1;
            skid_onehot_d = dec_onehot;
            skid_err_d    = dec_err;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_onehot_q  <= '0;
            out_err_q     <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_onehot_q <= '0;
            skid_err_q    <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            out_valid_q   <= out_valid_d;
            out_onehot_q  <= out_onehot_d;
            out_err_q     <= out_err_d;
            skid_valid_q  <= skid_valid_d;
            skid_onehot_q <= skid_onehot_d;
            skid_err_q    <= skid_err_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_err    = out_err_q;

`ifdef DECODER_PIPE_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && dec_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - vector table, hand sequences and random scoreboard for decoder_pipe.
module tb_decoder_pipe;

    localparam int SEL_W   = 4;
    localparam int OUTPUTS = 12;
`ifdef DECODER_PIPE_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               out_valid;
    logic               out_ready;
    logic [OUTPUTS-1:0] out_onehot;
    logic               out_err;
    logic [7:0]         err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_pipe #(.SEL_W(SEL_W), .OUTPUTS(OUTPUTS)) dut (
        .clock      (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  sel;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [11:0] e_oh;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUTPUTS-1:0] ref_onehot(input int s);
        logic [OUTPUTS-1:0] r;
        r = '0;
        if (s < OUTPUTS) r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] cnt_exp(input int v);
        return CNT_ON ? 8'(v) : 8'd0;
    endfunction

    task automatic step(input logic r, input logic iv, input logic [3:0] s, input logic ordy);
        reset     = r;
        in_valid  = iv;
        in_sel    = s;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int sent;
        int got;
        int mcnt;
        int s;

        vecs[0]  = '{1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 1'b1, 12'h020, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 12'h001, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 12'h800, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 4'd13, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 4'd2,  1'b1, 1'b1, 1'b1, 12'h004, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 1'b1, 12'h200, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'd2};

        reset = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_onehot",    32'(out_onehot), 32'd0);
        chk("rst_err",       32'(out_err),    32'd0);
        chk("rst_cnt",       32'(err_count),  32'd0);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].ordy);
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),   32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid),  32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_onehot", i),    32'(out_onehot), 32'(vecs[i].e_oh));
            chk($sformatf("vec%0d_err", i),       32'(out_err),    32'(vecs[i].e_err));
            chk($sformatf("vec%0d_cnt", i),       32'(err_count),  32'(cnt_exp(int'(vecs[i].e_cnt))));
        end

        // Saturation: 300 out-of-range accepts on top of the 2 already counted.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 4'd15, 1'b1);
            if (i == 99) chk("sat_cnt_mid", 32'(err_count), 32'(cnt_exp(102)));
        end
        chk("sat_cnt_final", 32'(err_count),  32'(cnt_exp(255)));
        chk("sat_err",       32'(out_err),    32'd1);
        chk("sat_onehot",    32'(out_onehot), 32'd0);
        step(1'b0, 1'b1, 4'd14, 1'b1);
        chk("sat_no_wrap",   32'(err_count),  32'(cnt_exp(255)));
        step(1'b0, 1'b0, 4'd0, 1'b1);
        chk("sat_drained",   32'(out_valid),  32'd0);

        // Fill both entries, then reset with a handshake in flight.
        step(1'b0, 1'b1, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd4, 1'b0);
        chk("full_in_ready", 32'(in_ready),   32'd0);
        chk("full_onehot",   32'(out_onehot), 32'h002);
        step(1'b1, 1'b1, 4'd6, 1'b1);
        chk("frst_out_valid", 32'(out_valid),  32'd0);
        chk("frst_in_ready",  32'(in_ready),   32'd1);
        chk("frst_cnt",       32'(err_count),  32'd0);
        chk("frst_onehot",    32'(out_onehot), 32'd0);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        chk("frst_discarded", 32'(out_valid),  32'd0);

        // Random traffic against a queue scoreboard.
        sent = 0; got = 0; mcnt = 0;
        for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
            reset     = 1'b0;
            in_valid  = (sent < 64) && ($urandom_range(0, 3) != 0);
            in_sel    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_word: got %0h expected none", out_onehot);
                end else begin
                    s = q.pop_front();
                    chk($sformatf("rand%0d_onehot", got), 32'(out_onehot), 32'(ref_onehot(s)));
                    chk($sformatf("rand%0d_err", got),    32'(out_err),    32'(s >= OUTPUTS));
                end
                got++;
            end else if (!out_valid) begin
                chk("rand_idle_zero", {31'd0, out_err} | 32'(out_onehot), 32'd0);
            end
            if (in_valid && in_ready) begin
                q.push_back(int'(in_sel));
                sent++;
                if (in_sel >= OUTPUTS && mcnt < 255) mcnt++;
            end
            @(posedge clk);
            #1;
        end
        chk("rand_sent",     32'(sent),      32'd64);
        chk("rand_received", 32'(got),       32'd64);
        chk("rand_leftover", 32'(q.size()),  32'd0);
        chk("rand_cnt",      32'(err_count), 32'(cnt_exp(mcnt)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL have parameter SEL_W, default 4, meaning select input width in bits (legal 1..6).
REQ-002 SHALL have parameter OUTPUTS, default 16, meaning one-hot output lines (legal 2..2**SEL_W).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream select word valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port in_sel  input  SEL_W  select value to decode.
REQ-008 SHALL have port out_valid  output  1  decoded word available.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the word this cycle.
REQ-010 SHALL have port out_onehot  output  OUTPUTS  decoded one-hot word.
REQ-011 SHALL have port out_err  output  1  presented word came from an out-of-range select.
REQ-012 SHALL have port err_count  output  8  saturating count of accepted out-of-range selects.

Function
REQ-013 SHALL accept a word when in_valid and in_ready are both high on a rising edge.
REQ-014 SHALL decode in-range sel (< OUTPUTS) to out_onehot bit sel set, all other bits clear, out_err low.
REQ-015 SHALL decode out-of-range sel (>= OUTPUTS) to out_onehot all zero, out_err high; word still passes through the handshake.
REQ-016 SHALL hold decoded words in a two-entry buffer: output register plus one skid register; decode is done before storage.
REQ-017 SHALL present an accepted word on out_* one cycle after acceptance when the output register is empty or being consumed (latency 1).
REQ-018 SHALL, when output register is full and not consumed, store the accepted word in the skid register.
REQ-019 SHALL drive in_ready from a register: high exactly when the skid register is empty; no combinational path from out_ready to in_ready.
REQ-020 SHALL, on consumption (out_valid and out_ready) with skid full, move the skid word into the output register next cycle and free the skid.
REQ-021 SHALL preserve acceptance order; no word dropped, duplicated or reordered.
REQ-022 SHALL keep out_onehot and out_err stable while out_valid high and out_ready low.
REQ-023 SHALL support simultaneous accept and consume each cycle: sustained throughput 1 word/cycle with both buffers' occupancy unchanged.
REQ-024 SHALL drive out_onehot zero and out_err low whenever out_valid is low.
REQ-025 SHALL treat out_ready as don't-care while out_valid is low and in_sel as don't-care while in_valid is low.

Reset
REQ-026 SHALL, while reset is high at a rising edge, clear both buffer entries regardless of in-flight handshakes; words in flight are discarded.
REQ-027 SHALL give after reset: out_valid 0, out_onehot 0, out_err 0, in_ready 1, err_count 0.
REQ-028 SHALL ignore in_valid on any edge where reset is high (no acceptance).

Configuration
REQ-029 SHALL, with macro DECODER_PIPE_ERRCNT_EN defined, increment err_count by 1 on each accepted out-of-range select, saturating at 255 (no wrap).
REQ-030 SHALL, without DECODER_PIPE_ERRCNT_EN, keep port err_count present and constant 0, with no counter logic instantiated.
REQ-031 SHALL leave all other behaviour identical in both builds.

Verification (bench: SEL_W=4, OUTPUTS=12, DECODER_PIPE_ERRCNT_EN defined unless noted)
REQ-032 SHALL cover: reset, accept sel=5 with out_ready=1 -> next cycle out_valid=1, out_onehot=12'h020, out_err=0.
REQ-033 SHALL cover: out_ready=0, accept sel=0 then sel=11 -> in_ready low after second accept; release out_ready -> 12'h001 then 12'h800 on consecutive cycles, in_ready high again.
REQ-034 SHALL cover: accept sel=13 -> out_onehot=12'h000, out_err=1, err_count=1; 300 further sel=15 accepts -> err_count=255.
REQ-035 SHALL cover: 64 random sels with random in_valid/out_ready -> scoreboard output order and values match, no loss.
REQ-036 SHALL cover: reset asserted with both entries full -> next cycle out_valid=0, in_ready=1, err_count=0.
REQ-037 SHALL cover: build without DECODER_PIPE_ERRCNT_EN, accept sel=14 -> out_err=1, err_count stays 0.
